video_timing_gen: RTL and testbench



---
 rtl/video_timing_gen.sv | 156 +++++++++++++++
 tb/tb_video_timing_gen.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel coordinates, sync, data enable,
// line/frame strobes and a completed-frame counter, all advancing on ce.
module video_timing_gen #(
    parameter int CORDW    = 10,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int FRAMEW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    output logic [CORDW-1:0]  sx,
    output logic [CORDW-1:0]  sy,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              line,
    output logic              frame,
    output logic [FRAMEW-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam longint COORD_MAX = (longint'(1) << CORDW) - 1;

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
        $fatal(1, "video_timing_gen: every timing parameter must be nonzero");
    end

    if (longint'(H_TOTAL - 1) > COORD_MAX || longint'(V_TOTAL - 1) > COORD_MAX) begin : g_bad_cordw
        $fatal(1, "video_timing_gen: CORDW too narrow for H_TOTAL/V_TOTAL");
    end

    // Thresholds are one bit wider than the coordinates so the porch sums cannot overflow.
    localparam int H_LAST_I   = H_TOTAL - 1;
    localparam int V_LAST_I   = V_TOTAL - 1;
    localparam int HS_START_I = H_ACTIVE + H_FP;
    localparam int HS_END_I   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START_I = V_ACTIVE + V_FP;
    localparam int VS_END_I   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [CORDW:0] H_LAST   = H_LAST_I[CORDW:0];
    localparam logic [CORDW:0] V_LAST   = V_LAST_I[CORDW:0];
    localparam logic [CORDW:0] H_ACT    = H_ACTIVE[CORDW:0];
    localparam logic [CORDW:0] V_ACT    = V_ACTIVE[CORDW:0];
    localparam logic [CORDW:0] HS_START = HS_START_I[CORDW:0];
    localparam logic [CORDW:0] HS_END   = HS_END_I[CORDW:0];
    localparam logic [CORDW:0] VS_START = VS_START_I[CORDW:0];
    localparam logic [CORDW:0] VS_END   = VS_END_I[CORDW:0];

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              load;
    logic [CORDW-1:0]  sx_d;
    logic [CORDW-1:0]  sy_d;
    logic [FRAMEW-1:0] frame_count_d;
    logic              hsync_d;
    logic              vsync_d;
    logic              de_d;
    logic              line_d;
    logic              frame_d;
    logic [CORDW:0]    sx_ext;
    logic [CORDW:0]    sy_ext;
    logic [CORDW:0]    sx_d_ext;
    logic [CORDW:0]    sy_d_ext;

    assign sx_ext = {1'b0, sx};
    assign sy_ext = {1'b0, sy};

    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        sx_d          = sx;
        sy_d          = sy;
        frame_count_d = frame_count;
        case (state_q)
            IDLE: begin
                if (ce) begin
                    state_d = RUN;
                    load    = 1'b1;
                    sx_d    = '0;
                    sy_d    = '0;
                end
            end
            RUN: begin
                if (ce) begin
                    load = 1'b1;
                    if (sx_ext == H_LAST) begin
                        sx_d = '0;
                        if (sy_ext == V_LAST) begin
                            sy_d          = '0;
                            frame_count_d = frame_count + FRAMEW'(1);
                        end else begin
                            sy_d = sy + CORDW'(1);
                        end
                    end else begin
                        sx_d = sx + CORDW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decode the pixel about to be registered so every output describes the same position.
    always_comb begin
        sx_d_ext = {1'b0, sx_d};
        sy_d_ext = {1'b0, sy_d};
        hsync_d  = ((sx_d_ext >= HS_START) && (sx_d_ext < HS_END)) ? H_POL : ~H_POL;
        vsync_d  = ((sy_d_ext >= VS_START) && (sy_d_ext < VS_END)) ? V_POL : ~V_POL;
        de_d     = (sx_d_ext < H_ACT) && (sy_d_ext < V_ACT);
        line_d   = (sx_d == '0);
        frame_d  = (sx_d == '0) && (sy_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sx          <= '0;
            sy          <= '0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            de          <= 1'b0;
            line        <= 1'b0;
            frame       <= 1'b0;
            frame_count <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                sx          <= sx_d;
                sy          <= sy_d;
                hsync       <= hsync_d;
                vsync       <= vsync_d;
                de          <= de_d;
                line        <= line_d;
                frame       <= frame_d;
                frame_count <= frame_count_d;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: default 640x480 mode plus a tiny 8x6 mode with inverted
// sync polarity and a 2-bit frame counter.
module tb_video_timing_gen;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit hpol, vpol;
        int fcmod;
    } mode_t;

    typedef struct {
        bit run;
        int x, y, fc;
        bit hs, vs, de, ln, fr;
    } mst_t;

    localparam mode_t BIG   = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 65536};
    localparam mode_t SMALL = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        b_rst = 1'b1, b_ce = 1'b0;
    logic [9:0]  b_sx, b_sy;
    logic        b_hs, b_vs, b_de, b_line, b_frame;
    logic [15:0] b_fc;

    logic        s_rst = 1'b1, s_ce = 1'b0;
    logic [3:0]  s_sx, s_sy;
    logic        s_hs, s_vs, s_de, s_line, s_frame;
    logic [1:0]  s_fc;

    video_timing_gen u_big (
        .clk(clk), .rst(b_rst), .ce(b_ce),
        .sx(b_sx), .sy(b_sy), .hsync(b_hs), .vsync(b_vs),
        .de(b_de), .line(b_line), .frame(b_frame), .frame_count(b_fc)
    );

    video_timing_gen #(
        .CORDW(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .FRAMEW(2)
    ) u_small (
        .clk(clk), .rst(s_rst), .ce(s_ce),
        .sx(s_sx), .sy(s_sy), .hsync(s_hs), .vsync(s_vs),
        .de(s_de), .line(s_line), .frame(s_frame), .frame_count(s_fc)
    );

    int   checks = 0;
    int   errors = 0;
    mst_t b_m, s_m;
    mst_t q_big[$];
    mst_t q_small[$];

    // Behavioural raster model written straight from the timing description.
    function automatic mst_t model_next(input mst_t s, input bit ce_v, input bit rst_v, input mode_t m);
        mst_t n;
        int   ht, vt, hs0, vs0;
        n   = s;
        ht  = m.ha + m.hf + m.hs + m.hb;
        vt  = m.va + m.vf + m.vs + m.vb;
        hs0 = m.ha + m.hf;
        vs0 = m.va + m.vf;
        if (rst_v) begin
            n.run = 1'b0; n.x = 0; n.y = 0; n.fc = 0;
            n.hs = !m.hpol; n.vs = !m.vpol;
            n.de = 1'b0; n.ln = 1'b0; n.fr = 1'b0;
            return n;
        end
        if (!ce_v) return n;
        if (!n.run) begin
            n.run = 1'b1; n.x = 0; n.y = 0;
        end else begin
            n.x = n.x + 1;
            if (n.x == ht) begin
                n.x = 0;
                n.y = n.y + 1;
                if (n.y == vt) begin
                    n.y  = 0;
                    n.fc = (n.fc + 1) % m.fcmod;
                end
            end
        end
        n.hs = (n.x >= hs0 && n.x < hs0 + m.hs) ? m.hpol : !m.hpol;
        n.vs = (n.y >= vs0 && n.y < vs0 + m.vs) ? m.vpol : !m.vpol;
        n.de = (n.x < m.ha) && (n.y < m.va);
        n.ln = (n.x == 0);
        n.fr = (n.x == 0) && (n.y == 0);
        return n;
    endfunction

    task automatic check_field(input string tag, input string fld, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %0d expected %0d", tag, fld, act, exp);
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] sx_a, input logic [31:0] sy_a,
                                input logic hs_a, input logic vs_a, input logic de_a,
                                input logic ln_a, input logic fr_a, input logic [31:0] fc_a,
                                input mst_t e);
        check_field(tag, "sx", sx_a, e.x);
        check_field(tag, "sy", sy_a, e.y);
        check_field(tag, "hsync", {31'b0, hs_a}, int'(e.hs));
        check_field(tag, "vsync", {31'b0, vs_a}, int'(e.vs));
        check_field(tag, "de", {31'b0, de_a}, int'(e.de));
        check_field(tag, "line", {31'b0, ln_a}, int'(e.ln));
        check_field(tag, "frame", {31'b0, fr_a}, int'(e.fr));
        check_field(tag, "frame_count", fc_a, e.fc);
    endtask

    // Drive one clock of stimulus and queue what the outputs must show after that edge.
    task automatic apply_big(input bit ce_v, input bit rst_v);
        b_ce  = ce_v;
        b_rst = rst_v;
        @(posedge clk);
        #1;
        b_m = model_next(b_m, ce_v, rst_v, BIG);
        q_big.push_back(b_m);
    endtask

    task automatic apply_small(input bit ce_v, input bit rst_v);
        s_ce  = ce_v;
        s_rst = rst_v;
        @(posedge clk);
        #1;
        s_m = model_next(s_m, ce_v, rst_v, SMALL);
        q_small.push_back(s_m);
    endtask

    always @(negedge clk) begin
        mst_t e;
        if (q_big.size() > 0) begin
            e = q_big.pop_front();
            check_output("big", 32'(b_sx), 32'(b_sy), b_hs, b_vs, b_de, b_line, b_frame, 32'(b_fc), e);
        end
        if (q_small.size() > 0) begin
            e = q_small.pop_front();
            check_output("small", 32'(s_sx), 32'(s_sy), s_hs, s_vs, s_de, s_line, s_frame, 32'(s_fc), e);
        end
    end

    initial begin
        int hs_low, hs_first, hs_last, de_cnt, ln_hi, vs_hi, hs_hi, sm_hs_first, fr_hi;
        int fr_fc[$];
        int fr_cyc[$];
        int rises[$];
        int exp_fc[5];
        bit prev;
        exp_fc = '{0, 1, 2, 3, 0};

        // Default mode: reset, then idle with ce low.
        apply_big(1'b0, 1'b1);
        apply_big(1'b0, 1'b1);
        check_field("big", "reset_hsync", {31'b0, b_hs}, 1);
        check_field("big", "reset_de", {31'b0, b_de}, 0);
        repeat (3) apply_big(1'b0, 1'b0);

        // First ce leaves IDLE presenting pixel (0,0) with both strobes.
        apply_big(1'b1, 1'b0);
        check_field("big", "first_frame", {31'b0, b_frame}, 1);
        check_field("big", "first_de", {31'b0, b_de}, 1);

        hs_low = 0; hs_first = -1; hs_last = -1; de_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (i > 0) apply_big(1'b1, 1'b0);
            if (b_hs == 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(b_sx);
                hs_last = int'(b_sx);
            end
            if (b_de) de_cnt++;
        end
        check_field("big", "hsync_low_count", 32'(hs_low), 96);
        check_field("big", "hsync_first_sx", 32'(hs_first), 656);
        check_field("big", "hsync_last_sx", 32'(hs_last), 751);
        check_field("big", "de_per_line", 32'(de_cnt), 640);
        apply_big(1'b1, 1'b0);
        check_field("big", "wrap_sy", 32'(b_sy), 1);
        check_field("big", "wrap_frame", {31'b0, b_frame}, 0);

        // ce every third clock: the line strobe at (0,2) must last three clocks.
        ln_hi = 0;
        for (int k = 0; k < 2400; k++) begin
            apply_big(k % 3 == 0, 1'b0);
            if (b_line) ln_hi++;
        end
        check_field("big", "line_strobe_clks", 32'(ln_hi), 3);
        check_field("big", "slow_sy", 32'(b_sy), 2);

        // Reset mid-line together with ce, then hold ce low, then restart.
        repeat (300) apply_big(1'b1, 1'b0);
        check_field("big", "pre_reset_sx", 32'(b_sx), 300);
        apply_big(1'b1, 1'b1);
        check_field("big", "mid_reset_sx", 32'(b_sx), 0);
        repeat (4) apply_big(1'b0, 1'b0);
        check_field("big", "held_reset_line", {31'b0, b_line}, 0);
        apply_big(1'b1, 1'b0);
        check_field("big", "restart_frame", {31'b0, b_frame}, 1);
        check_field("big", "restart_count", 32'(b_fc), 0);
        b_ce = 1'b0;

        // Small mode: 8x6 raster, active-high syncs, 2-bit frame counter.
        apply_small(1'b0, 1'b1);
        check_field("small", "reset_hsync", {31'b0, s_hs}, 0);
        check_field("small", "reset_vsync", {31'b0, s_vs}, 0);
        de_cnt = 0; hs_hi = 0; vs_hi = 0; sm_hs_first = -1;
        for (int p = 0; p < 241; p++) begin
            apply_small(1'b1, 1'b0);
            if (s_frame) begin
                fr_fc.push_back(int'(s_fc));
                fr_cyc.push_back(p);
            end
            if (p < 48) begin
                if (s_de) de_cnt++;
                if (s_vs) vs_hi++;
                if (s_hs) begin
                    hs_hi++;
                    if (sm_hs_first < 0) sm_hs_first = int'(s_sx);
                end
            end
            if (p == 47) begin
                check_field("small", "last_sx", 32'(s_sx), 7);
                check_field("small", "last_sy", 32'(s_sy), 5);
            end
            if (p == 48) begin
                check_field("small", "wrap_sx", 32'(s_sx), 0);
                check_field("small", "wrap_frame", {31'b0, s_frame}, 1);
            end
        end
        check_field("small", "de_per_frame", 32'(de_cnt), 12);
        check_field("small", "hsync_per_frame", 32'(hs_hi), 12);
        check_field("small", "hsync_first_sx", 32'(sm_hs_first), 5);
        check_field("small", "vsync_per_frame", 32'(vs_hi), 8);
        check_field("small", "frame_strobes", 32'(fr_fc.size()), 6);
        for (int i = 0; i < 5; i++)
            check_field("small", "frame_count_seq", (i < fr_fc.size()) ? 32'(fr_fc[i]) : 32'hFFFF_FFFF, exp_fc[i]);
        check_field("small", "frame_period", (fr_cyc.size() > 1) ? 32'(fr_cyc[1] - fr_cyc[0]) : 32'hFFFF_FFFF, 48);

        // Divided pixel rate: frame strobe lasts three clocks, period 144 clocks.
        apply_small(1'b0, 1'b1);
        fr_hi = 0; prev = 1'b0;
        for (int k = 0; k < 150; k++) begin
            apply_small(k % 3 == 0, 1'b0);
            if (s_frame) fr_hi++;
            if (s_frame && !prev) rises.push_back(k);
            prev = s_frame;
        end
        check_field("small", "slow_frame_clks", 32'(fr_hi), 6);
        check_field("small", "slow_period", (rises.size() > 1) ? 32'(rises[1] - rises[0]) : 32'hFFFF_FFFF, 144);

        apply_small(1'b1, 1'b1);
        check_field("small", "rst_ce_sx", 32'(s_sx), 0);
        check_field("small", "rst_ce_count", 32'(s_fc), 0);
        apply_small(1'b1, 1'b0);
        check_field("small", "restart_frame", {31'b0, s_frame}, 1);
        s_ce = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_field("tb", "big_queue_drained", 32'(q_big.size()), 0);
        check_field("tb", "small_queue_drained", 32'(q_small.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
